// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared region/state encodings and vector addresses for bus_responder
package bus_pkg;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_ROM,
        RGN_IO,
        RGN_NONE
    } region_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAM_ACC,
        ST_ROM_WAIT,
        ST_IO_WAIT,
        ST_DONE
    } state_t;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    // Region priority: RAM, then the IO page, then the upper half as ROM.
    function automatic region_t decode_region(input logic [15:0] addr,
                                              input int          ram_aw,
                                              input logic [7:0]  io_page);
        if ((addr >> ram_aw) == 16'd0) begin
            return RGN_RAM;
        end else if (addr[15:8] == io_page) begin
            return RGN_IO;
        end else if (addr[15]) begin
            return RGN_ROM;
        end
        return RGN_NONE;
    endfunction

endpackage

// File: rtl/io_handshake.sv
// rtl/io_handshake.sv - IO window strobe, ack capture and timeout for bus_responder
module io_handshake #(
    parameter int IO_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic       io_ack,
    input  logic [7:0] io_rdata,
    output logic       io_re,
    output logic       io_we,
    output logic [7:0] io_addr,
    output logic [7:0] io_wdata,
    output logic       o_done,
    output logic       o_timeout,
    output logic [7:0] o_rdata
);

    logic       r_re;
    logic       r_we;
    logic [7:0] r_cnt;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       w_active;
    logic       w_last;

    assign w_active  = r_re | r_we;
    assign w_last    = (r_cnt == 8'(IO_TIMEOUT - 1));
    // An ack in the final strobe cycle still completes normally.
    assign o_done    = w_active & io_ack;
    assign o_timeout = w_active & ~io_ack & w_last;
    assign o_rdata   = o_timeout ? 8'hFF : io_rdata;

    assign io_re    = r_re;
    assign io_we    = r_we;
    assign io_addr  = r_addr;
    assign io_wdata = r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= 8'd0;
            r_addr  <= 8'd0;
            r_wdata <= 8'd0;
        end else if (i_start) begin
            r_re    <= i_rw;
            r_we    <= ~i_rw;
            r_cnt   <= 8'd0;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end else if (o_done || o_timeout) begin
            r_re  <= 1'b0;
            r_we  <= 1'b0;
            r_cnt <= 8'd0;
        end else if (w_active) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU bus slave: RAM / ROM / IO / unmapped decode and wait-state sequencing
// Optional vector-table override of 0xFFFA-0xFFFF enabled by VECTOR_OVERRIDE_EN.
module bus_responder
    import bus_pkg::*;
#(
    parameter int         RAM_AW     = 11,
    parameter int         ROM_WAIT   = 2,
    parameter logic [7:0] IO_PAGE    = 8'h40,
    parameter int         IO_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] address,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        bus_err,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_re,
    output logic        io_we,
    input  logic [7:0]  io_rdata,
    input  logic        io_ack
);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic [7:0]        r_rdata;
    logic              r_ready;
    logic              r_bus_err;
    logic [14:0]       r_rom_addr;
    logic [7:0]        r_mem [0:(1<<RAM_AW)-1];

    region_t           w_region;
    logic              w_accept;
    logic              w_io_start;
    logic              w_io_done;
    logic              w_io_timeout;
    logic [7:0]        w_io_rdata;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_vec_sel;
    logic [7:0]        w_vec_rdata;

    assign w_region   = decode_region(address, RAM_AW, IO_PAGE);
    assign w_accept   = rst_n & req & (r_state == ST_IDLE);
    assign w_io_start = w_accept & (w_region == RGN_IO);
    assign w_ram_idx  = address[RAM_AW-1:0];

    assign rdata    = r_rdata;
    assign ready    = r_ready;
    assign bus_err  = r_bus_err;
    assign rom_addr = r_rom_addr;

`ifdef VECTOR_OVERRIDE_EN
    logic [7:0] r_vec [0:5];
    logic [5:0] r_vec_vld;
    logic [2:0] w_vec_idx;

    // 0xFFFA..0xFFFF map to slots 0..5; writes always land in the table,
    // reads only bypass ROM once the slot has been loaded.
    assign w_vec_idx   = address[2:0] - 3'd2;
    assign w_vec_sel   = (w_region == RGN_ROM) && (address >= VEC_NMI) &&
                         (!rw || r_vec_vld[w_vec_idx]);
    assign w_vec_rdata = r_vec[w_vec_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_vld <= 6'd0;
        end else if (w_accept && w_vec_sel && !rw) begin
            r_vec_vld[w_vec_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_vec_sel && !rw) begin
            r_vec[w_vec_idx] <= wdata;
        end
    end
`else
    assign w_vec_sel   = 1'b0;
    assign w_vec_rdata = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (w_accept && (w_region == RGN_RAM) && !rw) begin
            r_mem[w_ram_idx] <= wdata;
        end
    end

    io_handshake #(
        .IO_TIMEOUT(IO_TIMEOUT)
    ) u_io (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_io_start),
        .i_rw     (rw),
        .i_addr   (address[7:0]),
        .i_wdata  (wdata),
        .io_ack   (io_ack),
        .io_rdata (io_rdata),
        .io_re    (io_re),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .o_done   (w_io_done),
        .o_timeout(w_io_timeout),
        .o_rdata  (w_io_rdata)
    );

    // ready/bus_err are set on the edge entering RAM_ACC or DONE, so they
    // are high for exactly the cycle spent in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_rw       <= 1'b1;
            r_rdata    <= 8'h00;
            r_ready    <= 1'b0;
            r_bus_err  <= 1'b0;
            r_rom_addr <= 15'd0;
        end else begin
            r_ready   <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_rw <= rw;
                        if (w_vec_sel) begin
                            if (rw) begin
                                r_rdata <= w_vec_rdata;
                            end
                            r_ready <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            case (w_region)
                                RGN_RAM: begin
                                    if (rw) begin
                                        r_rdata <= r_mem[w_ram_idx];
                                    end
                                    r_ready <= 1'b1;
                                    r_state <= ST_RAM_ACC;
                                end
                                RGN_IO: begin
                                    r_state <= ST_IO_WAIT;
                                end
                                RGN_ROM: begin
                                    r_rom_addr <= address[14:0];
                                    if (rw) begin
                                        r_cnt   <= 4'(ROM_WAIT);
                                        r_state <= ST_ROM_WAIT;
                                    end else begin
                                        r_ready   <= 1'b1;
                                        r_bus_err <= 1'b1;
                                        r_state   <= ST_DONE;
                                    end
                                end
                                default: begin
                                    if (rw) begin
                                        r_rdata <= 8'hFF;
                                    end
                                    r_ready <= 1'b1;
                                    r_state <= ST_DONE;
                                end
                            endcase
                        end
                    end
                end
                ST_RAM_ACC: begin
                    r_state <= ST_IDLE;
                end
                ST_ROM_WAIT: begin
                    // The wait state always lasts at least one cycle.
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_rdata <= rom_data;
                        r_ready <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_IO_WAIT: begin
                    if (w_io_done || w_io_timeout) begin
                        if (r_rw || w_io_timeout) begin
                            r_rdata <= w_io_rdata;
                        end
                        r_bus_err <= w_io_timeout;
                        r_ready   <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - scoreboard bench for bus_responder with a behavioural bus model
module tb_bus_responder;
    import bus_pkg::*;

    localparam int         RAM_AW     = 11;
    localparam int         ROM_WAIT   = 2;
    localparam logic [7:0] IO_PAGE    = 8'h40;
    localparam int         IO_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [15:0] address = 16'd0;
    logic        rw = 1'b1;
    logic [7:0]  wdata = 8'd0;
    logic [7:0]  rdata;
    logic        ready;
    logic        bus_err;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic        io_re;
    logic        io_we;
    logic [7:0]  io_rdata = 8'd0;
    logic        io_ack = 1'b0;

    bus_responder #(
        .RAM_AW    (RAM_AW),
        .ROM_WAIT  (ROM_WAIT),
        .IO_PAGE   (IO_PAGE),
        .IO_TIMEOUT(IO_TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .address (address),
        .rw      (rw),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .bus_err (bus_err),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .io_addr (io_addr),
        .io_wdata(io_wdata),
        .io_re   (io_re),
        .io_we   (io_we),
        .io_rdata(io_rdata),
        .io_ack  (io_ack)
    );

    always #5 clk = ~clk;

    // ROM image: every byte is its low address byte xor 0xC8 (0x7FFC -> 0x34).
    assign rom_data = rom_addr[7:0] ^ 8'hC8;

    int          checks = 0;
    int          failures = 0;
    int unsigned cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [7:0]  rdata;
        logic        err;
        int          lat;
        logic        chk_rom;
        logic [14:0] rom_a;
        int unsigned start;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_ram    [0:(1<<RAM_AW)-1];
    bit         m_ram_ok [0:(1<<RAM_AW)-1];
    logic [7:0] m_vec    [0:5];
    bit         m_vec_ok [0:5];
    logic [7:0] m_rdata = 8'h00;

    bit         io_expected = 1'b0;
    bit         io_exp_rw = 1'b1;
    int         io_exp_delay = 0;
    logic [7:0] io_exp_val = 8'd0;
    logic [7:0] io_exp_addr = 8'd0;
    logic [7:0] io_exp_wdata = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One CPU access: model computes the response, scoreboard gets it, then
    // the bus is driven until ready (inputs scrambled while busy).
    task automatic access(input logic [15:0] a, input bit r, input logic [7:0] d,
                          input int dly, input logic [7:0] iov);
        exp_t e;
        int   vi;
        bit   got;
        e.chk_rom = 1'b0;
        e.rom_a   = a[14:0];
        e.err     = 1'b0;
        e.lat     = 2;
        io_expected = 1'b0;
        if (a < 16'(1 << RAM_AW)) begin
            if (r) m_rdata = m_ram[a[RAM_AW-1:0]];
            else begin
                m_ram[a[RAM_AW-1:0]]    = d;
                m_ram_ok[a[RAM_AW-1:0]] = 1'b1;
            end
        end else if (a[15:8] == IO_PAGE) begin
            io_expected  = 1'b1;
            io_exp_rw    = r;
            io_exp_delay = dly;
            io_exp_val   = iov;
            io_exp_addr  = a[7:0];
            io_exp_wdata = d;
            if (dly >= 1 && dly <= IO_TIMEOUT) begin
                e.lat = dly + 2;
                if (r) m_rdata = iov;
            end else begin
                e.lat   = IO_TIMEOUT + 2;
                e.err   = 1'b1;
                m_rdata = 8'hFF;
            end
        end else if (a[15]) begin
            vi = int'(a) - int'(VEC_NMI);
`ifdef VECTOR_OVERRIDE_EN
            if (vi >= 0 && (!r || m_vec_ok[vi])) begin
                if (r) m_rdata = m_vec[vi];
                else begin
                    m_vec[vi]    = d;
                    m_vec_ok[vi] = 1'b1;
                end
            end else
`endif
            if (r) begin
                m_rdata   = a[7:0] ^ 8'hC8;
                e.lat     = ROM_WAIT + 2;
                e.chk_rom = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end else begin
            if (r) m_rdata = 8'hFF;
        end
        e.rdata = m_rdata;

        @(negedge clk);
        address = a;
        rw      = r;
        wdata   = d;
        req     = 1'b1;
        e.start = cycle;
        sb.push_back(e);
        got = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                break;
            end
            address = 16'($urandom);
            rw      = 1'($urandom_range(0, 1));
            wdata   = 8'($urandom);
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ready timeout: addr 0x%0h got no ready, expected one within 40 cycles", a);
            void'(sb.pop_back());
        end
        req = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic rand_access();
        logic [15:0] a;
        bit          r;
        int          k;
        r = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 4);
        case (k)
            0: begin
                a = 16'($urandom_range(0, (1 << RAM_AW) - 1));
                if (r && !m_ram_ok[a[RAM_AW-1:0]]) r = 1'b0;
            end
            1: a = {IO_PAGE, 8'($urandom)};
            2: a = 16'($urandom_range(32'h8000, 32'hFFFF));
            3: a = VEC_NMI + 16'($urandom_range(0, 5));
            default: begin
                a = 16'($urandom_range(1 << RAM_AW, 32'h7FFF));
                if (a[15:8] == IO_PAGE) a[15:8] = 8'h20;
            end
        endcase
        access(a, r, 8'($urandom), $urandom_range(0, IO_TIMEOUT + 2), 8'($urandom));
    endtask

    // Monitor: pops and compares on every ready pulse.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready) begin
                if (prev) begin
                    checks++;
                    failures++;
                    $display("FAIL ready width: ready high 2 cycles, expected 1");
                end
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected ready: got ready with rdata 0x%0h, expected none", rdata);
                end else begin
                    e = sb.pop_front();
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    check("bus_err", 32'(bus_err), 32'(e.err));
                    check("latency", cycle - e.start + 1, 32'(e.lat));
                    if (e.chk_rom) check("rom_addr", 32'(rom_addr), 32'(e.rom_a));
                end
            end else if (bus_err) begin
                checks++;
                failures++;
                $display("FAIL bus_err without ready: got 1, expected 0");
            end
            prev = ready;
        end
    end

    // IO device: acks in the programmed strobe cycle, random ack noise when idle.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (io_re || io_we) begin
                cnt++;
                if (cnt == 1) begin
                    if (!io_expected) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected io strobe: got re=%0b we=%0b, expected none", io_re, io_we);
                    end else begin
                        check("io_re", 32'(io_re), 32'(io_exp_rw));
                        check("io_we", 32'(io_we), 32'(!io_exp_rw));
                        check("io_addr", 32'(io_addr), 32'(io_exp_addr));
                        if (!io_exp_rw) check("io_wdata", 32'(io_wdata), 32'(io_exp_wdata));
                    end
                end
                if (cnt == io_exp_delay) begin
                    io_ack   = 1'b1;
                    io_rdata = io_exp_val;
                end else begin
                    io_ack   = 1'b0;
                    io_rdata = 8'($urandom);
                end
            end else begin
                if (cnt > 0 && io_expected)
                    check("io strobe length", 32'(cnt),
                          32'((io_exp_delay >= 1 && io_exp_delay <= IO_TIMEOUT) ? io_exp_delay : IO_TIMEOUT));
                cnt      = 0;
                io_ack   = 1'($urandom_range(0, 1));
                io_rdata = 8'($urandom);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset rdata", 32'(rdata), 32'h00);
        check("reset ready", 32'(ready), 32'h0);
        check("reset bus_err", 32'(bus_err), 32'h0);
        check("reset io strobes", 32'({io_re, io_we}), 32'h0);
        check("reset io_addr", 32'(io_addr), 32'h0);
        check("reset io_wdata", 32'(io_wdata), 32'h0);
        check("reset rom_addr", 32'(rom_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        access(16'h0123, 1'b0, 8'hA5, 0, 8'h00);
        access(16'h0123, 1'b1, 8'h00, 0, 8'h00);
        access(VEC_RST,  1'b1, 8'h00, 0, 8'h00);
        access(16'h4007, 1'b1, 8'h00, 3, 8'h5A);
        access(16'h4010, 1'b0, 8'h3C, 0, 8'h00);
        access(16'h2000, 1'b1, 8'h00, 0, 8'h00);
        access(16'h9000, 1'b0, 8'h77, 0, 8'h00);
        access(16'h9000, 1'b1, 8'h00, 0, 8'h00);
        access(16'h07FF, 1'b0, 8'h96, 0, 8'h00);
        access(16'h07FF, 1'b1, 8'h00, 0, 8'h00);
        access(16'h0800, 1'b1, 8'h00, 0, 8'h00);
        access(16'hFFFF, 1'b1, 8'h00, 0, 8'h00);
        access(16'h40FF, 1'b1, 8'h00, IO_TIMEOUT, 8'hC3);
        access(16'h4080, 1'b1, 8'h00, IO_TIMEOUT + 1, 8'h11);
        access(16'hFFFD, 1'b0, 8'h80, 0, 8'h00);
        access(16'hFFFD, 1'b1, 8'h00, 0, 8'h00);
        access(VEC_RST,  1'b1, 8'h00, 0, 8'h00);
        access(VEC_IRQ,  1'b1, 8'h00, 0, 8'h00);

        // Reset in the middle of an IO read that is never acknowledged.
        io_expected  = 1'b1;
        io_exp_rw    = 1'b1;
        io_exp_delay = 0;
        io_exp_addr  = 8'h22;
        @(negedge clk);
        address = 16'h4022;
        rw      = 1'b1;
        req     = 1'b1;
        repeat (3) @(negedge clk);
        check("io_re before reset", 32'(io_re), 32'h1);
        #2;
        io_expected = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("io_re async drop", 32'(io_re), 32'h0);
        check("ready in reset", 32'(ready), 32'h0);
        check("rdata in reset", 32'(rdata), 32'h00);
        req     = 1'b0;
        m_rdata = 8'h00;
        for (int i = 0; i < 6; i++) m_vec_ok[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        access(16'h0123, 1'b1, 8'h00, 0, 8'h00);
        access(16'hFFFD, 1'b1, 8'h00, 0, 8'h00);

        for (int i = 0; i < 250; i++) rand_access();

        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
